dffr_pipe_sg: RTL and testbench
===============================

DFFR_PIPE_SG -- requirements
Module: dffr_pipe_sg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per stage (1..64).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (1..16).
REQ-003 SHALL have parameter RST_VAL, default 0, WIDTH-bit data value loaded on reset.
REQ-004 SHALL have port CP  input  1  clock; all state updates on rising edge; one clock only.
REQ-005 SHALL have port RN  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port SE  input  1  scan enable; 1 = scan shift mode.
REQ-007 SHALL have port SI  input  1  scan serial input.
REQ-008 SHALL have port SO  output  1  scan serial output.
REQ-009 SHALL have port IN_VALID  input  1  upstream data valid.
REQ-010 SHALL have port IN_READY  output  1  pipeline can accept D this cycle.
REQ-011 SHALL have port D  input  WIDTH  upstream data.
REQ-012 SHALL have port OUT_VALID  output  1  Q valid (stage DEPTH-1 valid bit).
REQ-013 SHALL have port OUT_READY  input  1  downstream accepts Q this cycle.
REQ-014 SHALL have port Q  output  WIDTH  data of stage DEPTH-1.

Function
REQ-015 SHALL hold per stage i (0..DEPTH-1) one valid flop v[i] and WIDTH data flops d[i].
REQ-016 SHALL compute rdy[DEPTH]=OUT_READY, rdy[i] = ~v[i] | rdy[i+1], combinationally; IN_READY = rdy[0] & ~SE.
REQ-017 SHALL, with SE=0 and rdy[i]=1, load v[i] from upstream valid (IN_VALID for i=0, v[i-1] otherwise) and d[i] from upstream data only when upstream valid=1.
REQ-018 SHALL hold d[i] unchanged when its stage empties (no data toggling on bubbles); v[i] and d[i] hold when rdy[i]=0.
REQ-019 SHALL give a latency of DEPTH cycles from IN_VALID&IN_READY to OUT_VALID in a flowing pipe, and throughput of one word per cycle.
REQ-020 SHALL collapse bubbles: with OUT_READY=0, stages fill until all DEPTH v[i]=1, then IN_READY=0.
REQ-021 SHALL never drop or duplicate a word; a word transfers at output exactly on OUT_VALID&OUT_READY.
REQ-022 SHALL, with SE=1, form one shift chain of length DEPTH*(WIDTH+1): order stage 0 first, within a stage v[i] then d[i] bit 0..WIDTH-1; each cycle every bit takes its predecessor, the first bit takes SI.
REQ-023 SHALL drive SO from d[DEPTH-1] bit WIDTH-1 at all times.
REQ-024 SHALL force IN_READY=0 and OUT_VALID=0 while SE=1; handshake inputs are ignored.
REQ-025 SHALL resume normal operation the cycle after SE falls, using the shifted-in contents as pipeline state.

Reset
REQ-026 SHALL, on a rising CP edge with RN=0, set all v[i]=0 and all d[i]=RST_VAL, regardless of SE, IN_VALID, OUT_READY.
REQ-027 SHALL thereby give reset outputs OUT_VALID=0, Q=RST_VAL, SO=RST_VAL[WIDTH-1], IN_READY=~SE.
REQ-028 SHALL discard all in-flight words on reset mid-operation; no word is presented after reset until newly accepted.

Structure
REQ-029 SHALL place WIDTH/DEPTH/RST_VAL defaults and the scan-chain-length constant in shared package sg_pkg.
REQ-030 SHALL implement one stage (valid flop, data flops, load/hold/scan muxing, sync active-low reset) as sub-module dffr_stage_sg, instantiated DEPTH times.
REQ-031 SHALL contain no latches and no combinational path from D to Q.

Verification
REQ-032 SHALL cover streaming: WIDTH=8, DEPTH=4, OUT_READY=1, push 0x01..0x10 back-to-back -> Q shows 0x01 with OUT_VALID=1 four cycles after first accept, then one word per cycle, in order.
REQ-033 SHALL cover backpressure/full: OUT_READY=0, push 0xA0..0xA5 -> IN_READY falls after 4 accepts (0xA0..0xA3); raising OUT_READY drains 0xA0..0xA3 in order, then 0xA4, 0xA5.
REQ-034 SHALL cover bubbles: IN_VALID alternating 1/0 with data 0x11,-,0x22 -> OUT_VALID pattern 1,0,1 and d[i] unchanged during empty cycles.
REQ-035 SHALL cover scan: SE=1, shift 36-bit pattern 0x9_A5C3_3C5A for 36 cycles, then 36 more -> SO replays the pattern bit-for-bit; OUT_VALID=0, IN_READY=0 throughout.
REQ-036 SHALL cover reset mid-operation: RST_VAL=0x5A, pipe full, RN=0 one cycle with SE=1 and IN_VALID=1 -> next cycle OUT_VALID=0, Q=0x5A, no pre-reset word ever emerges.

Source files
------------

// File: rtl/sg_pkg.sv
// Shared defaults and helpers for the scan-able valid/ready register pipe.
package sg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam logic [63:0] DEF_RST_VAL = 64'h0;

  // Per-stage action chosen for the next rising edge (reset is handled separately).
  typedef enum logic [1:0] {
    STAGE_HOLD = 2'd0,
    STAGE_LOAD = 2'd1,
    STAGE_SCAN = 2'd2
  } stage_mode_e;

  // One valid bit plus WIDTH data bits per stage are threaded onto the scan chain.
  function automatic int scan_chain_len(input int width, input int depth);
    return depth * (width + 1);
  endfunction

  localparam int DEF_CHAIN_LEN = DEF_DEPTH * (DEF_WIDTH + 1);

endpackage

// File: rtl/dffr_stage_sg.sv
// One pipe stage: a valid flop and WIDTH data flops with load/hold/scan muxing
// and a synchronous active-low reset.
module dffr_stage_sg
  import sg_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_en,
  input  logic             scan_in,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             rdy,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  stage_mode_e mode;

  // Scan wins over the handshake; otherwise the stage moves only when downstream has room.
  always_comb begin
    mode = STAGE_HOLD;
    if (scan_en) begin
      mode = STAGE_SCAN;
    end else if (rdy) begin
      mode = STAGE_LOAD;
    end
  end

  // State update: data only captured with a valid word, so bubbles never toggle d.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= 1'b0;
      d <= RST_VAL;
    end else begin
      case (mode)
        STAGE_LOAD: begin
          v <= up_valid;
          if (up_valid) begin
            d <= up_data;
          end
        end
        STAGE_SCAN: begin
          v <= scan_in;
          d <= WIDTH'({d, v});
        end
        default: begin
          v <= v;
          d <= d;
        end
      endcase
    end
  end

endmodule

// File: rtl/dffr_pipe_sg.sv
// DEPTH-stage valid/ready register pipe with bubble collapsing and a full scan chain.
module dffr_pipe_sg
  import sg_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
  input  logic             CP,
  input  logic             RN,
  input  logic             SE,
  input  logic             SI,
  output logic             SO,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] D,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Q
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d [DEPTH];

  // Stage i may move when any stage from i to the end is empty or the sink is taking Q;
  // expanded from v directly so the ready chain has no self-referencing vector.
  always_comb begin
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      acc = OUT_READY;
      for (int j = i; j < DEPTH; j++) begin
        acc = acc | ~v[j];
      end
      rdy[i] = acc;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic             scan_in;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_first
      assign up_valid = IN_VALID;
      assign up_data  = D;
      assign scan_in  = SI;
    end else begin : g_rest
      assign up_valid = v[i-1];
      assign up_data  = d[i-1];
      assign scan_in  = d[i-1][WIDTH-1];
    end

    dffr_stage_sg #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk      (CP),
      .rst_n    (RN),
      .scan_en  (SE),
      .scan_in  (scan_in),
      .up_valid (up_valid),
      .up_data  (up_data),
      .rdy      (rdy[i]),
      .v        (v[i]),
      .d        (d[i])
    );
  end

  // Handshake outputs are masked during scan so no transfer can happen mid-shift.
  always_comb begin
    IN_READY  = rdy[0] & ~SE;
    OUT_VALID = v[DEPTH-1] & ~SE;
    Q         = d[DEPTH-1];
    SO        = d[DEPTH-1][WIDTH-1];
  end

endmodule

// File: tb/tb_dffr_pipe_sg.sv
// Scoreboard bench for dffr_pipe_sg: directed words are queued on accept and
// a monitor pops and compares them whenever the pipe hands a word downstream.
module tb_dffr_pipe_sg;
  import sg_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] RST_VAL = 8'h5A;
  localparam int CHAIN = DEF_CHAIN_LEN;

  logic             CP = 1'b0;
  logic             RN = 1'b0;
  logic             SE = 1'b0;
  logic             SI = 1'b0;
  logic             SO;
  logic             IN_VALID = 1'b0;
  logic             IN_READY;
  logic [WIDTH-1:0] D = '0;
  logic             OUT_VALID;
  logic             OUT_READY = 1'b0;
  logic [WIDTH-1:0] Q;

  dffr_pipe_sg #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL)
  ) dut (
    .CP        (CP),
    .RN        (RN),
    .SE        (SE),
    .SI        (SI),
    .SO        (SO),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .D         (D),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Q         (Q)
  );

  always #5 CP = ~CP;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               pops = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_word;
  bit               acc_armed = 0;
  bit               lat_armed = 0;
  int               acc_cyc = 0;
  int               last_acc_cyc = 0;
  int               lat_out_cyc = 0;

  always @(posedge CP) cyc++;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Present one word and hold it until accepted; the expected word is queued on acceptance.
  task automatic apply_stimulus(input logic [WIDTH-1:0] data);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    IN_VALID = 1'b1;
    D = data;
    while (!done) begin
      @(negedge CP);
      if (IN_READY) begin
        exp_q.push_back(data);
        last_acc_cyc = cyc;
        if (acc_armed) begin
          acc_cyc = cyc;
          acc_armed = 0;
        end
        done = 1;
      end else if (n > 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout got=%0h required=accepted", data);
        done = 1;
      end
      n++;
      @(posedge CP);
      #1;
    end
    IN_VALID = 1'b0;
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge CP);
      n++;
    end
    #1;
    check_output("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every downstream transfer must match the oldest outstanding word.
  always @(negedge CP) begin
    if (OUT_VALID && lat_armed) begin
      lat_out_cyc = cyc;
      lat_armed = 0;
    end
    if (OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word got=%0h required=none", Q);
      end else begin
        exp_word = exp_q.pop_front();
        check_output("q_word", 64'(Q), 64'(exp_word));
        pops++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [35:0] pat;
    int          pops_before;
    int          n;
    pat = 36'h9_A5C3_3C5A;

    // Reset state
    RN = 1'b0;
    tick();
    tick();
    @(negedge CP);
    check_output("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check_output("rst_q", 64'(Q), 64'(RST_VAL));
    check_output("rst_so", 64'(SO), 64'(RST_VAL[WIDTH-1]));
    check_output("rst_in_ready", 64'(IN_READY), 64'd1);
    SE = 1'b1;
    #1;
    check_output("rst_in_ready_se", 64'(IN_READY), 64'd0);
    SE = 1'b0;
    @(posedge CP);
    #1;
    RN = 1'b1;
    tick();

    // Streaming 0x01..0x10 back-to-back
    $display("[TB] streaming");
    OUT_READY = 1'b1;
    pops_before = pops;
    acc_armed = 1;
    lat_armed = 1;
    for (int i = 1; i <= 16; i++) apply_stimulus(WIDTH'(i));
    wait_drain();
    check_output("stream_latency", 64'(lat_out_cyc - acc_cyc), 64'd4);
    check_output("stream_throughput", 64'(last_acc_cyc - acc_cyc), 64'd15);
    check_output("stream_pops", 64'(pops - pops_before), 64'd16);

    // Backpressure: four words fill the pipe, then IN_READY drops
    $display("[TB] backpressure");
    OUT_READY = 1'b0;
    acc_armed = 1;
    for (int i = 0; i < 4; i++) apply_stimulus(8'hA0 + WIDTH'(i));
    check_output("full_accept_span", 64'(last_acc_cyc - acc_cyc), 64'd3);
    IN_VALID = 1'b1;
    D = 8'hA4;
    @(negedge CP);
    check_output("full_in_ready", 64'(IN_READY), 64'd0);
    check_output("full_out_valid", 64'(OUT_VALID), 64'd1);
    check_output("full_q_head", 64'(Q), 64'hA0);
    tick();
    OUT_READY = 1'b1;
    apply_stimulus(8'hA4);
    apply_stimulus(8'hA5);
    wait_drain();

    // Bubble: 0x11, idle, 0x22 gives OUT_VALID 1,0,1 with Q holding across the gap
    $display("[TB] bubbles");
    apply_stimulus(8'h11);
    tick();
    apply_stimulus(8'h22);
    n = 0;
    @(negedge CP);
    while (!OUT_VALID && n < 20) begin
      @(negedge CP);
      n++;
    end
    check_output("bubble_v0", 64'(OUT_VALID), 64'd1);
    check_output("bubble_q0", 64'(Q), 64'h11);
    @(negedge CP);
    check_output("bubble_v1", 64'(OUT_VALID), 64'd0);
    check_output("bubble_q1_hold", 64'(Q), 64'h11);
    @(negedge CP);
    check_output("bubble_v2", 64'(OUT_VALID), 64'd1);
    check_output("bubble_q2", 64'(Q), 64'h22);
    @(posedge CP);
    #1;
    wait_drain();

    // Scan: shift the pattern in, then shift it out on SO
    $display("[TB] scan chain length %0d", CHAIN);
    SE = 1'b1;
    IN_VALID = 1'b1;
    for (int i = 0; i < CHAIN; i++) begin
      SI = pat[i];
      @(negedge CP);
      check_output("scan_in_ready", 64'(IN_READY), 64'd0);
      check_output("scan_out_valid", 64'(OUT_VALID), 64'd0);
      tick();
    end
    for (int i = 0; i < CHAIN; i++) begin
      SI = 1'b0;
      @(negedge CP);
      check_output($sformatf("scan_so_%0d", i), 64'(SO), 64'(pat[i]));
      check_output("scan_out_valid2", 64'(OUT_VALID), 64'd0);
      tick();
    end
    IN_VALID = 1'b0;
    SE = 1'b0;
    @(negedge CP);
    check_output("resume_out_valid", 64'(OUT_VALID), 64'd0);
    check_output("resume_q", 64'(Q), 64'h00);
    check_output("resume_in_ready", 64'(IN_READY), 64'd1);
    tick();

    // Reset mid-operation with SE and IN_VALID high: all in-flight words vanish
    $display("[TB] reset mid-operation");
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(8'hB0 + WIDTH'(i));
    SE = 1'b1;
    IN_VALID = 1'b1;
    D = 8'hC7;
    RN = 1'b0;
    @(posedge CP);
    #1;
    exp_q.delete();
    RN = 1'b1;
    SE = 1'b0;
    IN_VALID = 1'b0;
    @(negedge CP);
    check_output("midrst_out_valid", 64'(OUT_VALID), 64'd0);
    check_output("midrst_q", 64'(Q), 64'(RST_VAL));
    check_output("midrst_so", 64'(SO), 64'(RST_VAL[WIDTH-1]));
    check_output("midrst_in_ready", 64'(IN_READY), 64'd1);
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CP);
      check_output("midrst_quiet", 64'(OUT_VALID), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
